// File: rtl/mistral_m10k_fifo_ctrl.sv
// FIFO controller for one simple-dual-port M10K RAM, with a two-entry
// in-order skid buffer that hides the RAM's one-cycle read latency.
module mistral_m10k_fifo_ctrl #(
  parameter int CFG_ABITS = 10,
  parameter int CFG_DBITS = 10
) (
  input  logic                 CLK1,
  input  logic                 ARST_N,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  input  logic [CFG_DBITS-1:0] WR_DATA,
  output logic                 RD_VALID,
  input  logic                 RD_READY,
  output logic [CFG_DBITS-1:0] RD_DATA,
  output logic [CFG_ABITS-1:0] A1ADDR,
  output logic [CFG_DBITS-1:0] A1DATA,
  output logic                 A1EN,
  output logic [CFG_ABITS-1:0] B1ADDR,
  output logic                 B1EN,
  input  logic [CFG_DBITS-1:0] B1DATA,
  output logic [CFG_ABITS+1:0] COUNT
);

  logic [CFG_ABITS:0]   r_wptr;
  logic [CFG_ABITS:0]   r_rptr;
  logic                 r_inflight;
  logic [1:0]           r_occ;
  logic [CFG_DBITS-1:0] r_skid [2];

  logic [CFG_ABITS:0]   w_ram_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic [2:0]           w_level;
  logic [1:0]           w_occ_base;
  logic [1:0]           w_occ_next;
  logic [CFG_DBITS-1:0] w_skid_next [2];

  // Wrap-bit pointers: ram_count reaches D exactly when the MSBs differ
  // and the low bits match, so bit CFG_ABITS alone flags RAM-full.
  assign w_ram_count = r_wptr - r_rptr;
  assign WR_READY    = ARST_N & ~w_ram_count[CFG_ABITS];
  assign w_push      = WR_VALID & WR_READY;

  assign RD_VALID = (r_occ != 2'd0);
  assign RD_DATA  = r_skid[0];
  assign w_pop    = RD_VALID & RD_READY;

  // Skid slots committed after this cycle's pop; a new read only issues
  // if its data will still have a free slot when it lands.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (w_ram_count != '0) && (w_level < 3'd2);

  assign A1EN   = w_push;
  assign A1ADDR = r_wptr[CFG_ABITS-1:0];
  assign A1DATA = WR_DATA;
  assign B1EN   = w_issue;
  assign B1ADDR = r_rptr[CFG_ABITS-1:0];

  assign COUNT = {1'b0, w_ram_count}
               + {{(CFG_ABITS+1){1'b0}}, r_inflight}
               + {{CFG_ABITS{1'b0}}, r_occ};

  always_comb begin
    w_skid_next[0] = r_skid[0];
    w_skid_next[1] = r_skid[1];
    w_occ_base     = r_occ - {1'b0, w_pop};
    if (w_pop) begin
      w_skid_next[0] = r_skid[1];
    end
    // Returning RAM data lands behind whatever survives the pop.
    if (r_inflight) begin
      if (w_occ_base == 2'd0) begin
        w_skid_next[0] = B1DATA;
      end else begin
        w_skid_next[1] = B1DATA;
      end
    end
    w_occ_next = w_occ_base + {1'b0, r_inflight};
  end

  always_ff @(posedge CLK1 or negedge ARST_N) begin
    if (!ARST_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_skid[0]  <= '0;
      r_skid[1]  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_inflight <= w_issue;
      r_occ      <= w_occ_next;
      r_skid[0]  <= w_skid_next[0];
      r_skid[1]  <= w_skid_next[1];
    end
  end

endmodule

// File: doc/mistral_m10k_fifo_ctrl.md
MISTRAL_M10K_FIFO_CTRL -- requirements
Module: mistral_m10k_fifo_ctrl

Interface
REQ-001 Parameter CFG_ABITS, default 10: RAM address width; RAM depth D = 2^CFG_ABITS.
REQ-002 Parameter CFG_DBITS, default 10: data width.
REQ-003 CLK1  input  1: single clock; all state updates on its rising edge.
REQ-004 ARST_N  input  1: asynchronous, active-low reset.
REQ-005 WR_VALID  input  1: producer offers WR_DATA.
REQ-006 WR_READY  output  1: controller accepts a word this cycle.
REQ-007 WR_DATA  input  CFG_DBITS: write word.
REQ-008 RD_VALID  output  1: RD_DATA holds the oldest word.
REQ-009 RD_READY  input  1: consumer takes RD_DATA this cycle.
REQ-010 RD_DATA  output  CFG_DBITS: head word; registered.
REQ-011 A1ADDR  output  CFG_ABITS: RAM write address.
REQ-012 A1DATA  output  CFG_DBITS: RAM write data; equals WR_DATA.
REQ-013 A1EN  output  1: RAM write enable.
REQ-014 B1ADDR  output  CFG_ABITS: RAM read address.
REQ-015 B1EN  output  1: RAM read enable.
REQ-016 B1DATA  input  CFG_DBITS: RAM read data; valid the cycle after B1EN.
REQ-017 COUNT  output  CFG_ABITS+2: words accepted and not yet popped.

Function
REQ-018 The block SHALL drive one M10K simple-dual-port RAM as a FIFO of D RAM entries plus a 2-entry output skid buffer.
REQ-019 State: wptr, rptr (CFG_ABITS+1 bits, MSB = wrap bit); inflight (1 bit); skid occupancy occ (0..2).
REQ-020 ram_count = wptr - rptr, modulo 2^(CFG_ABITS+1); range 0..D.
REQ-021 WR_READY SHALL be 1 iff ram_count < D and ARST_N = 1.
REQ-022 Push = WR_VALID && WR_READY; A1EN = push; A1ADDR = wptr[CFG_ABITS-1:0]; wptr increments on push, wrapping through D to 0 with the MSB toggled.
REQ-023 Read issue SHALL occur iff ram_count != 0 and occ + inflight - pop < 2, where pop = RD_VALID && RD_READY.
REQ-024 On issue: B1EN = 1, B1ADDR = rptr[CFG_ABITS-1:0], rptr increments, and inflight is set for the next cycle; otherwise B1EN = 0 and inflight clears.
REQ-025 ram_count SHALL use the registered wptr, so a word written in cycle t is not readable before cycle t+1; a same-address read and write in the same cycle SHALL never occur.
REQ-026 When inflight = 1, B1DATA SHALL be captured into the skid unconditionally; the skid cannot overflow because of REQ-023.
REQ-027 The skid SHALL be strictly in-order; RD_DATA = skid head, RD_VALID = (occ != 0).
REQ-028 Simultaneous pop and capture SHALL keep occ constant and advance the head.
REQ-029 Latency: a write to an empty FIFO in cycle t SHALL produce RD_VALID = 1 in cycle t+3.
REQ-030 Throughput: with WR_VALID and RD_READY held at 1, the FIFO SHALL sustain one push and one pop per cycle.
REQ-031 COUNT = ram_count + inflight + occ; maximum D+2; registered-state derived, no combinational path from inputs.
REQ-032 Simultaneous push and pop at full or empty SHALL follow REQ-021 to REQ-028 with no special casing; a push when RAM-full is refused, not dropped.

Reset
REQ-033 While ARST_N = 0: wptr = rptr = 0, inflight = 0, occ = 0, RD_VALID = 0, COUNT = 0, WR_READY = 0, A1EN = 0, B1EN = 0, RD_DATA = 0.
REQ-034 Reset mid-operation SHALL discard all queued words, including any in-flight read; RAM contents are not cleared and are never re-exposed.
REQ-035 The first cycle after ARST_N rises SHALL present WR_READY = 1 and RD_VALID = 0.

Verification (CFG_ABITS=4, CFG_DBITS=8, D=16)
REQ-036 Single word: push 0xA5 at cycle 0 with RD_READY = 0 -> B1EN at cycle 1, RD_VALID = 1 with RD_DATA = 0xA5 from cycle 3, COUNT = 1 held.
REQ-037 Fill: push 0x00..0x13 with RD_READY = 0 -> 18 accepted (16 RAM + 2 skid), WR_READY = 0 afterwards, COUNT = 18; drain -> 0x00..0x11 in order.
REQ-038 Streaming: WR_VALID = RD_READY = 1 for 100 cycles with an incrementing pattern -> after 3-cycle fill, one pop per cycle, no gaps, pointers wrap cleanly at 16.
REQ-039 Backpressure: random RD_READY at 30% with random WR_VALID -> scoreboard order preserved, never occ > 2, never B1EN with ram_count = 0.
REQ-040 Mid-run reset: assert ARST_N = 0 while inflight = 1 and COUNT = 7 -> RD_VALID and COUNT drop to 0 immediately; the next push of 0x5A is the first word read out.
